usram_arb: RTL and testbench

- Two-requester arbiter for the single-port 64-bit usram. Requesters are the host path (ICB interface unit, CSR/usram writes) and the MHSA engine (operand fetch and result write-back).
- Round-robin arbitration, with optional burst lock bounded by BURST_MAX beats.
- Registered usram command stage; read data returned to the winning requester with fixed latency.
- Sits between the interface manage unit, the engine datapath and the usram macro.

---
 rtl/usram_arb.sv | 92 +++++++++
 tb/tb_usram_arb.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/usram_arb.sv
// usram_arb: round-robin host/engine arbiter for the single-port usram with bounded burst lock and fixed-latency read return
module usram_arb #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 64,
  parameter int BURST_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              h_req,
  output logic              h_gnt,
  input  logic              h_we,
  input  logic              h_lock,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  input  logic              e_req,
  output logic              e_gnt,
  input  logic              e_we,
  input  logic              e_lock,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [DATA_W-1:0] e_wdata,
  output logic              e_rvalid,
  output logic [DATA_W-1:0] e_rdata,
  output logic [ADDR_W-1:0] usram_addr,
  output logic [DATA_W-1:0] usram_wdata,
  output logic              usram_write_en,
  output logic              usram_read_en,
  input  logic [DATA_W-1:0] usram_rdata,
  output logic              busy
);
  localparam int CW = $clog2(BURST_MAX + 1);
  logic              lock_act, lock_own, last_grant, v1, o1, v2, o2;
  logic              own_req, locked, acc, win, w_we, w_lock, keep;
  logic [CW-1:0]     cnt, cnt_n;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata, h_hold, e_hold;
  always_comb begin
    own_req = lock_own ? e_req : h_req;
    locked  = lock_act & own_req;
    h_gnt   = locked ? !lock_own : h_req & (!e_req | last_grant);
    e_gnt   = locked ? lock_own : e_req & (!h_req | !last_grant);
    win     = e_req & e_gnt;
    acc     = (h_req & h_gnt) | win;
    w_we    = win ? e_we : h_we;
    w_lock  = win ? e_lock : h_lock;
    w_addr  = win ? e_addr : h_addr;
    w_wdata = win ? e_wdata : h_wdata;
    cnt_n   = (locked ? cnt : '0) + 1'b1;
    keep    = acc & w_lock & (cnt_n != CW'(BURST_MAX));
  end
  assign h_rvalid = v2 & !o2;
  assign e_rvalid = v2 & o2;
  assign h_rdata  = h_rvalid ? usram_rdata : h_hold;
  assign e_rdata  = e_rvalid ? usram_rdata : e_hold;
  assign busy     = locked | v1 | v2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      usram_addr     <= '0;
      usram_wdata    <= '0;
      usram_write_en <= 1'b0;
      usram_read_en  <= 1'b0;
      last_grant     <= 1'b1;
      lock_act       <= 1'b0;
      lock_own       <= 1'b0;
      cnt            <= '0;
      v1             <= 1'b0;
      o1             <= 1'b0;
      v2             <= 1'b0;
      o2             <= 1'b0;
      h_hold         <= '0;
      e_hold         <= '0;
    end else begin
      usram_write_en <= acc & w_we;
      usram_read_en  <= acc & !w_we;
      v1             <= acc & !w_we;
      o1             <= win;
      v2             <= v1;
      o2             <= o1;
      lock_act       <= keep;
      lock_own       <= acc ? win : lock_own;
      cnt            <= keep ? cnt_n : '0;
      h_hold         <= h_rdata;
      e_hold         <= e_rdata;
      if (acc) begin
        last_grant  <= win;
        usram_addr  <= w_addr;
        usram_wdata <= w_wdata;
      end
    end
  end
endmodule

// File: tb/tb_usram_arb.sv
// tb_usram_arb: directed self-checking bench for usram_arb with a behavioural usram model
module tb_usram_arb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        h_req = 0, h_we = 0, h_lock = 0, e_req = 0, e_we = 0, e_lock = 0;
  logic [15:0] h_addr = 0, e_addr = 0;
  logic [63:0] h_wdata = 0, e_wdata = 0;
  logic        h_gnt, e_gnt, h_rvalid, e_rvalid, usram_write_en, usram_read_en, busy;
  logic [63:0] h_rdata, e_rdata, usram_wdata, usram_rdata;
  logic [15:0] usram_addr;
  logic [63:0] mem [256];
  int checks = 0;
  int fails = 0;
  localparam logic [63:0] D10 = 64'h1122334455667788;
  localparam logic [63:0] DA  = 64'h00000000000000A1;
  localparam logic [63:0] DB  = 64'h00000000000000B2;
  localparam logic [63:0] D20 = 64'hDEADBEEF01234567;

  usram_arb dut (
    .clk(clk), .rst_n(rst_n),
    .h_req(h_req), .h_gnt(h_gnt), .h_we(h_we), .h_lock(h_lock), .h_addr(h_addr),
    .h_wdata(h_wdata), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .e_req(e_req), .e_gnt(e_gnt), .e_we(e_we), .e_lock(e_lock), .e_addr(e_addr),
    .e_wdata(e_wdata), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
    .usram_addr(usram_addr), .usram_wdata(usram_wdata), .usram_write_en(usram_write_en),
    .usram_read_en(usram_read_en), .usram_rdata(usram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (usram_write_en) mem[usram_addr[7:0]] <= usram_wdata;
    usram_rdata <= mem[usram_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    h_req = 0; h_lock = 0; e_req = 0; e_lock = 0;
  endtask

  task automatic host(input logic we, input logic [15:0] a, input logic [63:0] d);
    h_req = 1; h_we = we; h_addr = a; h_wdata = d; h_lock = 0;
  endtask

  task automatic eng(input logic we, input logic lk, input logic [15:0] a, input logic [63:0] d);
    e_req = 1; e_we = we; e_lock = lk; e_addr = a; e_wdata = d;
  endtask

  initial begin
    #3;
    chk("rst_addr", usram_addr, 0);
    chk("rst_we", usram_write_en, 0);
    chk("rst_re", usram_read_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hrv", h_rvalid, 0);
    chk("rst_erd", e_rdata, 0);
    #19 rst_n = 1;
    step();
    host(1, 16'h0010, D10);
    #1;
    chk("wr_hgnt", h_gnt, 1);
    chk("wr_egnt", e_gnt, 0);
    step();
    idle();
    chk("wr_we", usram_write_en, 1);
    chk("wr_re", usram_read_en, 0);
    chk("wr_addr", usram_addr, 16'h0010);
    chk("wr_data", usram_wdata, D10);
    step();
    chk("wr_pulse", usram_write_en, 0);
    step();
    host(0, 16'h0010, 0);
    step();
    idle();
    chk("rd_re", usram_read_en, 1);
    chk("rd_addr", usram_addr, 16'h0010);
    chk("rd_busy", busy, 1);
    step();
    chk("rd_hrv", h_rvalid, 1);
    chk("rd_hrd", h_rdata, D10);
    chk("rd_erv", e_rvalid, 0);
    step();
    chk("rd_hrv_end", h_rvalid, 0);
    chk("rd_hold", h_rdata, D10);
    chk("rd_busy_end", busy, 0);
    host(1, 16'h0001, DA);
    step();
    host(1, 16'h0002, DB);
    step();
    idle();
    step();
    host(0, 16'h0010, 0);
    step();
    idle();
    chk("mr_re", usram_read_en, 1);
    rst_n = 0;
    #1;
    chk("mr_re0", usram_read_en, 0);
    chk("mr_addr0", usram_addr, 0);
    chk("mr_wd0", usram_wdata, 0);
    chk("mr_busy0", busy, 0);
    chk("mr_hrd0", h_rdata, 0);
    #2 rst_n = 1;
    step();
    chk("mr_hrv_a", h_rvalid, 0);
    chk("mr_busy_a", busy, 0);
    step();
    chk("mr_hrv_b", h_rvalid, 0);
    for (int c = 0; c < 9; c++) begin
      if (c < 6) begin
        host(0, 16'h0001, 0);
        eng(0, 0, 16'h0002, 0);
      end else idle();
      #1;
      if (c < 6) begin
        chk($sformatf("rr_hgnt%0d", c), h_gnt, (c % 2) == 0);
        chk($sformatf("rr_egnt%0d", c), e_gnt, (c % 2) == 1);
      end
      if (c >= 1 && c <= 6) begin
        chk($sformatf("rr_re%0d", c), usram_read_en, 1);
        chk($sformatf("rr_addr%0d", c), usram_addr, ((c - 1) % 2) == 0 ? 16'h0001 : 16'h0002);
      end
      if (c >= 2 && c <= 7) begin
        chk($sformatf("rr_hrv%0d", c), h_rvalid, (c % 2) == 0);
        chk($sformatf("rr_erv%0d", c), e_rvalid, (c % 2) == 1);
        if (c % 2 == 0) chk($sformatf("rr_hrd%0d", c), h_rdata, DA);
        else chk($sformatf("rr_erd%0d", c), e_rdata, DB);
      end
      step();
    end
    host(0, 16'h0001, 0);
    step();
    idle();
    step();
    step();
    for (int c = 0; c < 18; c++) begin
      host(0, 16'h0003, 0);
      eng(0, 1, 16'h0004, 0);
      #1;
      chk($sformatf("lk_egnt%0d", c), e_gnt, c < 16 || c == 17);
      chk($sformatf("lk_hgnt%0d", c), h_gnt, c == 16);
      step();
    end
    idle();
    step();
    step();
    step();
    for (int c = 0; c < 3; c++) begin
      eng(1, 1, 16'h0006, 0);
      #1;
      chk($sformatf("ld_egnt%0d", c), e_gnt, 1);
      if (c == 2) chk("ld_busy_lk", busy, 1);
      step();
    end
    e_req = 0;
    host(1, 16'h0005, 64'h55);
    #1;
    chk("ld_hgnt", h_gnt, 1);
    chk("ld_egnt", e_gnt, 0);
    chk("ld_busy", busy, 0);
    step();
    idle();
    chk("ld_we", usram_write_en, 1);
    chk("ld_addr", usram_addr, 16'h0005);
    chk("ld_busy_after", busy, 0);
    step();
    eng(1, 0, 16'h0020, D20);
    #1;
    chk("bb_egnt", e_gnt, 1);
    step();
    e_req = 0;
    host(0, 16'h0020, 0);
    #1;
    chk("bb_hgnt", h_gnt, 1);
    chk("bb_we", usram_write_en, 1);
    chk("bb_waddr", usram_addr, 16'h0020);
    step();
    idle();
    chk("bb_re", usram_read_en, 1);
    chk("bb_we0", usram_write_en, 0);
    step();
    chk("bb_hrv", h_rvalid, 1);
    chk("bb_hrd", h_rdata, D20);
    chk("bb_erv", e_rvalid, 0);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
